abus_arbiter: RTL and testbench

- Shares the single abus (8-bit address, 16-bit data) between NREQ masters (cpu, DMA, debug).
- Stops multiple modules from driving bus.addr/bus.data at the same time.
- Grants one master at a time, round-robin, and sequences one transaction per grant using a valid/ready handshake to the memory side.
- Timeout protection: a hung slave cannot lock up the bus.

---
 rtl/abus_arbiter.sv | 112 +++++++++++
 tb/tb_abus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/abus_arbiter.sv
// abus_arbiter: round-robin owner of the shared abus, one valid/ready transaction per grant with slave timeout
module abus_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    req_we_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic               err_o,
  output logic [DW-1:0]      rdata_o,
  output logic               bus_valid_o,
  output logic               bus_we_o,
  output logic [AW-1:0]      bus_addr_o,
  output logic [DW-1:0]      bus_data_o,
  input  logic               bus_ready_i,
  input  logic [DW-1:0]      bus_rdata_i
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, win, win_n, pick;
  logic            pick_ok, we_q, we_n, err_q, err_n, tmo;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   data_q, data_n, rdata_q, rdata_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NREQ-1:0] win_oh;
  // lowest offset from ptr wins, so scan downward and let the last hit stick
  always_comb begin
    pick = '0;
    pick_ok = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[IW'((int'(ptr) + i) % NREQ)]) begin
        pick = IW'((int'(ptr) + i) % NREQ);
        pick_ok = 1'b1;
      end
  end
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    win_n = win;
    we_n = we_q;
    addr_n = addr_q;
    data_n = data_q;
    rdata_n = rdata_q;
    err_n = err_q;
    cnt_n = cnt;
    case (state)
      IDLE: if (pick_ok) begin
        state_n = BUS;
        win_n = pick;
        we_n = req_we_i[pick];
        addr_n = req_addr_i[int'(pick)*AW +: AW];
        data_n = req_wdata_i[int'(pick)*DW +: DW];
      end
      BUS: if (bus_ready_i) begin
        state_n = DONE;
        rdata_n = we_q ? '0 : bus_rdata_i;
      end else if (tmo) begin
        state_n = DONE;
        rdata_n = '0;
        err_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      DONE: begin
        state_n = IDLE;
        ptr_n = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        cnt_n = '0;
        err_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      win <= win_n;
      we_q <= we_n;
      addr_q <= addr_n;
      data_q <= data_n;
      rdata_q <= rdata_n;
      err_q <= err_n;
      cnt <= cnt_n;
    end
  assign win_oh = NREQ'(1) << win;
  assign gnt_o = state != IDLE ? win_oh : '0;
  assign done_o = state == DONE ? win_oh : '0;
  assign err_o = state == DONE && err_q;
  assign rdata_o = state == DONE ? rdata_q : '0;
  assign bus_valid_o = state == BUS;
  assign bus_we_o = bus_valid_o && we_q;
  assign bus_addr_o = bus_valid_o ? addr_q : '0;
  assign bus_data_o = bus_valid_o ? data_q : '0;
endmodule

// File: tb/tb_abus_arbiter.sv
// tb_abus_arbiter: directed table, multi-cycle corner sequences and a randomized transaction-level scoreboard
module tb_abus_arbiter;
  localparam int N = 3, AW = 8, DW = 16, TO = 16;
  logic clk, rst_n;
  logic [N-1:0] req_i, req_we_i, gnt_o, done_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic err_o, bus_valid_o, bus_we_o, bus_ready_i;
  logic [DW-1:0] rdata_o, bus_data_o, bus_rdata_i;
  logic [AW-1:0] bus_addr_o;
  int n_cmp, n_bad;

  abus_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .bus_valid_o(bus_valid_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int m; logic we; logic [7:0] addr; logic [15:0] wd; int dly; logic [15:0] srd;
    int len; logic [15:0] rd; logic err;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_txn(input vec_t v);
    int len;
    logic bad;
    len = 0;
    bad = 0;
    bus_ready_i = 0;
    req_we_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    req_we_i[v.m] = v.we;
    req_addr_i[v.m*AW +: AW] = v.addr;
    req_wdata_i[v.m*DW +: DW] = v.wd;
    req_i = N'(1) << v.m;
    @(negedge clk);
    chk("latency_valid", bus_valid_o, 1);
    while (bus_valid_o && len < 40) begin
      len++;
      if (bus_addr_o !== v.addr || bus_we_o !== v.we || bus_data_o !== v.wd || gnt_o !== (N'(1) << v.m)) bad = 1;
      bus_ready_i = (len - 1 == v.dly);
      bus_rdata_i = bus_ready_i ? v.srd : ~v.srd;
      req_addr_i[v.m*AW +: AW] = 8'($urandom);
      req_wdata_i[v.m*DW +: DW] = 16'($urandom);
      @(negedge clk);
    end
    bus_ready_i = 0;
    chk("txn_bus_stable", bad, 0);
    chk("txn_valid_len", len, v.len);
    chk("txn_done", done_o, N'(1) << v.m);
    chk("txn_gnt_in_done", gnt_o, N'(1) << v.m);
    chk("txn_rdata", rdata_o, v.rd);
    chk("txn_err", err_o, v.err);
    chk("txn_bus_quiet", {bus_valid_o, bus_we_o, bus_addr_o, bus_data_o}, 0);
    req_i = '0;
    @(negedge clk);
    chk("done_single_pulse", {done_o, gnt_o, err_o}, 0);
  endtask

  task automatic contention();
    int dc[$];
    int dm[$];
    logic two;
    two = 0;
    req_i = 3'b011;
    req_we_i = '0;
    bus_ready_i = 1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ($countones(gnt_o) > 1) two = 1;
      if (done_o != 0) begin
        dc.push_back(c);
        dm.push_back(done_o == 3'b001 ? 0 : done_o == 3'b010 ? 1 : 9);
      end
    end
    chk("cont_gnt_onehot", two, 0);
    if (dm.size() < 4) chk("cont_done_count", dm.size(), 4);
    else begin
      for (int k = 0; k < 4; k++) chk("cont_master_order", dm[k], k % 2);
      chk("cont_interleave", dc[1] - dc[0], 3);
      chk("cont_period_m0", dc[2] - dc[0], 6);
      chk("cont_period_m1", dc[3] - dc[1], 6);
    end
    req_i = '0;
    repeat (4) @(negedge clk);
    bus_ready_i = 0;
  endtask

  task automatic reset_mid_bus();
    int w;
    logic [N-1:0] fg, fd;
    req_we_i = '0;
    req_addr_i = '0;
    req_addr_i[1*AW +: AW] = 8'h44;
    bus_ready_i = 0;
    req_i = 3'b010;
    w = 0;
    @(negedge clk);
    while (!bus_valid_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rst_prep_valid", bus_valid_o, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_ctrl", {gnt_o, done_o, err_o, bus_valid_o, bus_we_o, bus_addr_o}, 0);
    chk("async_rst_data", {bus_data_o, rdata_o}, 0);
    req_i = 3'b011;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    fg = '0;
    fd = '0;
    for (int c = 0; c < 20 && fd == 0; c++) begin
      @(negedge clk);
      if (fg == 0) fg = gnt_o;
      if (fd == 0) fd = done_o;
    end
    chk("rst_first_gnt", fg, 3'b001);
    chk("rst_first_done", fd, 3'b001);
    req_i = '0;
    bus_ready_i = 1;
    repeat (4) @(negedge clk);
    bus_ready_i = 0;
  endtask

  task automatic random_phase();
    int ptr_m, w, len, dly, n_txn;
    logic in_t, exp_we;
    logic [7:0] exp_a;
    logic [15:0] exp_d, exp_rd;
    logic [N-1:0] prev_req;
    ptr_m = 0;
    w = 0;
    len = 0;
    dly = 0;
    n_txn = 0;
    in_t = 0;
    exp_we = 0;
    exp_a = 0;
    exp_d = 0;
    exp_rd = 0;
    req_i = '0;
    bus_ready_i = 0;
    do_reset();
    prev_req = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_gnt_onehot", $countones(gnt_o) <= 1, 1);
      if (bus_valid_o && !in_t) begin
        chk("rnd_grant_had_req", prev_req != 0, 1);
        w = rr(prev_req, ptr_m);
        if (w < 0) w = 0;
        in_t = 1;
        len = 0;
        dly = $urandom_range(0, 20);
        exp_we = req_we_i[w];
        exp_a = req_addr_i[w*AW +: AW];
        exp_d = req_wdata_i[w*DW +: DW];
        exp_rd = 0;
      end
      if (in_t && bus_valid_o) begin
        len++;
        chk("rnd_bus_payload", {gnt_o, bus_we_o, bus_addr_o, bus_data_o}, {N'(1) << w, exp_we, exp_a, exp_d});
        if (len > TO) chk("rnd_len_bound", len, TO);
        bus_ready_i = (len - 1 == dly);
        bus_rdata_i = 16'($urandom);
        if (bus_ready_i && !exp_we) exp_rd = bus_rdata_i;
        if ($urandom_range(0, 2) == 0) begin
          req_we_i[w] = 1'($urandom);
          req_addr_i[w*AW +: AW] = 8'($urandom);
          req_wdata_i[w*DW +: DW] = 16'($urandom);
        end
      end else begin
        chk("rnd_bus_quiet", {bus_we_o, bus_addr_o, bus_data_o}, 0);
        bus_ready_i = 1'($urandom);
        bus_rdata_i = 16'($urandom);
        if (in_t) begin
          chk("rnd_done", done_o, N'(1) << w);
          chk("rnd_err", err_o, dly >= TO);
          chk("rnd_rdata", rdata_o, exp_rd);
          chk("rnd_len", len, dly < TO ? dly + 1 : TO);
          ptr_m = (w + 1) % N;
          req_i[w] = 0;
          in_t = 0;
          n_txn++;
        end else chk("rnd_no_done", {done_o, err_o}, 0);
      end
      for (int i = 0; i < N; i++)
        if (!req_i[i] && $urandom_range(0, 3) == 0) begin
          req_i[i] = 1;
          req_we_i[i] = 1'($urandom);
          req_addr_i[i*AW +: AW] = 8'($urandom);
          req_wdata_i[i*DW +: DW] = 16'($urandom);
        end
      prev_req = req_i;
    end
    chk("rnd_progress", n_txn >= 100, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tbl[0] = '{0, 1'b0, 8'h01, 16'h0000, 2, 16'h0005, 3, 16'h0005, 1'b0};
    tbl[1] = '{1, 1'b1, 8'h80, 16'hBEEF, 0, 16'h1234, 1, 16'h0000, 1'b0};
    tbl[2] = '{2, 1'b0, 8'h3C, 16'h0000, 99, 16'h7777, 16, 16'h0000, 1'b1};
    tbl[3] = '{0, 1'b0, 8'h55, 16'h0000, 15, 16'hA5A5, 16, 16'hA5A5, 1'b0};
    tbl[4] = '{1, 1'b0, 8'hFF, 16'h0000, 14, 16'h0F0F, 15, 16'h0F0F, 1'b0};
    tbl[5] = '{2, 1'b1, 8'h00, 16'h1111, 16, 16'h2222, 16, 16'h0000, 1'b1};
    tbl[6] = '{0, 1'b1, 8'h7E, 16'hCAFE, 3, 16'hFFFF, 4, 16'h0000, 1'b0};
    req_i = '0;
    req_we_i = '0;
    req_addr_i = '0;
    req_wdata_i = '0;
    bus_ready_i = 0;
    bus_rdata_i = '0;
    rst_n = 1;
    #1 rst_n = 0;
    @(negedge clk);
    chk("reset_ctrl", {gnt_o, done_o, err_o, bus_valid_o, bus_we_o, bus_addr_o}, 0);
    chk("reset_data", {bus_data_o, rdata_o}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_no_req", {gnt_o, bus_valid_o}, 0);
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);
    contention();
    reset_mid_bus();
    random_phase();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
